// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: one-cycle multiply, 32-cycle restoring divide.
// Ports: clk, rst; start, mulDiv_op, op_a, op_b, kill in; busy, done, result out.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mulDiv_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] res_q, res_d;

  logic        op_ok, is_div, is_rem, dsgn;
  logic        div0, ovf;
  logic [31:0] a_mag, b_mag, spec_res;

  always_comb begin
    op_ok = 1'b0;
    case (mulDiv_op)
      4'b0011, 4'b0101, 4'b0111, 4'b0110,
      4'b1001, 4'b1011, 4'b1101, 4'b1111: op_ok = 1'b1;
      default:                            op_ok = 1'b0;
    endcase
  end

  assign is_div = mulDiv_op[3];
  assign is_rem = mulDiv_op[2];
  assign dsgn   = (mulDiv_op[1:0] == 2'b01);
  assign div0   = (op_b == 32'd0);
  assign ovf    = dsgn && (op_a == 32'h8000_0000)
                       && (op_b == 32'hFFFF_FFFF);
  assign a_mag  = (dsgn && op_a[31]) ? -op_a : op_a;
  assign b_mag  = (dsgn && op_b[31]) ? -op_b : op_b;

  always_comb begin
    if (div0)
      spec_res = is_rem ? op_a : 32'hFFFF_FFFF;
    else
      spec_res = is_rem ? 32'd0 : 32'h8000_0000;
  end

  // Multiply on latched operands; op_q[1:0] selects operand signedness.
  logic        sa, sb;
  logic [63:0] ma, mb, prod;
  logic [31:0] mul_res;

  assign sa      = (op_q[1:0] != 2'b11);
  assign sb      = (op_q[1:0] == 2'b01);
  assign ma      = {{32{sa & a_q[31]}}, a_q};
  assign mb      = {{32{sb & b_q[31]}}, b_q};
  assign prod    = ma * mb;
  assign mul_res = op_q[2] ? prod[63:32] : prod[31:0];

  // One restoring step. a_q shifts the dividend out and the quotient in.
  // Since rem_q < b_q, shl - b_q < 2^32 when it fits; bit 32 is the borrow.
  logic [32:0] shl, sub;
  logic        ge;
  logic [31:0] rem_n, quo_n, quo_fix, rem_fix;

  assign shl     = {rem_q, a_q[31]};
  assign sub     = shl - {1'b0, b_q};
  assign ge      = ~sub[32];
  assign rem_n   = ge ? sub[31:0] : shl[31:0];
  assign quo_n   = {a_q[30:0], ge};
  assign quo_fix = qneg_q ? -quo_n : quo_n;
  assign rem_fix = rneg_q ? -rem_n : rem_n;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start && op_ok && !kill) begin
          op_d   = mulDiv_op[2:0];
          qneg_d = dsgn & (op_a[31] ^ op_b[31]);
          rneg_d = dsgn & op_a[31];
          if (!is_div) begin
            a_d     = op_a;
            b_d     = op_b;
            state_d = S_MUL;
          end else if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            a_d     = a_mag;
            b_d     = b_mag;
            rem_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          res_d   = mul_res;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          a_d   = quo_n;
          rem_d = rem_n;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            res_d   = op_q[2] ? rem_fix : quo_fix;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      cnt_q   <= 6'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  // A kill seen while in DONE suppresses the pulse.
  assign done   = (state_q == S_DONE) && !kill;
  assign result = res_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst, input, 1: synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port start, input, 1: request strobe; accepted only when the FSM is in IDLE.
REQ-005 Port mulDiv_op, input, 4: operation code, as listed in REQ-011.
REQ-006 Port op_a, input, 32: rs1 operand, sampled on the accept edge.
REQ-007 Port op_b, input, 32: rs2 operand, sampled on the accept edge.
REQ-008 Port kill, input, 1: pipeline flush request (exception or mispredict).
REQ-009 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-010 Port done, output, 1: one-cycle pulse marking result valid; port result, output, 32: final value, held until the next accept or reset.

Function
REQ-011 The opcode encoding SHALL be:
- 0011 MUL, 0101 MULH, 0111 MULHU, 0110 MULHSU
- 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU
- 0000 no-op
- bit3 = div/rem, bit2 = high-half or rem, bits[1:0] = 01 signed, 11 unsigned, 10 signed×unsigned.
REQ-012 start SHALL be ignored, with no state change, when mulDiv_op is 0000 or any code not listed in REQ-011.
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE; on accept it latches the opcode and both operands.
REQ-014 IDLE→MUL on an accepted MUL-class op.
- MUL computes the 64-bit product of the sign/zero-extended 33-bit operands.
- MUL→DONE after one cycle.
- MUL/MULH/MULHSU/MULHU return product[31:0]/[63:32]/[63:32]/[63:32].
REQ-015 IDLE→DIV on an accepted DIV-class op with no special case.
- DIV performs 32 restoring-division iterations, one per cycle, on operand magnitudes (signed ops) or raw values (unsigned ops).
- DIV→DONE after the 32nd iteration.
- A 6-bit iteration counter resets to 0 on entry to DIV.
REQ-016 Sign fix-up, applied to the final value:
- quotient negated when the signs of op_a and op_b differ (DIV);
- remainder takes the sign of op_a (REM).
REQ-017 Divide by zero SHALL go IDLE→DONE directly.
- DIV/DIVU → 0xFFFFFFFF.
- REM/REMU → op_a.
REQ-018 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, signed ops) SHALL go IDLE→DONE directly.
- DIV → 0x80000000.
- REM → 0.
REQ-019 Latency, with the accept edge at cycle N:
- special cases: done at N+1;
- MUL class: done at N+2;
- DIV class: done at N+33.
REQ-020 In DONE, done=1 and result is valid; DONE→IDLE unconditionally on the next edge, and start is not accepted in DONE.
REQ-021 result SHALL update only on the edge entering DONE.
REQ-022 kill asserted in MUL, DIV or DONE SHALL force IDLE on the next edge, with no done pulse and result unchanged; kill in IDLE SHALL block acceptance of a coincident start.
REQ-023 start and kill asserted in the same IDLE cycle: kill SHALL win and the request is dropped.

Reset
REQ-024 When rst is sampled high, the block SHALL enter state IDLE with busy=0, done=0, result=0x00000000 and iteration counter 0.
REQ-025 Reset SHALL have priority over start and kill.
REQ-026 Reset mid-operation SHALL abort without a done pulse.

Verification
REQ-027 MUL, op_a=0xFFFFFFFF, op_b=2 -> done at N+2, result=0xFFFFFFFE; MULHU on the same operands -> result=0x00000001.
REQ-028 DIV, op_a=-7, op_b=2 -> done at N+33, result=0xFFFFFFFD; REM on the same operands -> result=0xFFFFFFFF.
REQ-029 DIVU, op_b=0, op_a=0x1234 -> done at N+1, result=0xFFFFFFFF; REMU on the same operands -> result=0x00001234.
REQ-030 DIV, op_a=0x80000000, op_b=0xFFFFFFFF -> done at N+1, result=0x80000000; REM on the same operands -> result=0.
REQ-031 DIVU accepted, kill at N+10 -> IDLE at N+11, busy=0, no done, prior result retained; a new start at N+11 is accepted.
REQ-032 start while busy, a start with opcode 0000, and rst at N+5 of a DIV -> all ignored or aborted, with outputs matching REQ-024 after reset.
